bottle_param_entry: RTL and testbench
=====================================

Name: bottle_param_entry

Overview:
- Operator-entry stage that sits directly upstream of the pill-count/bottle-sequence counter.
- Turns four raw push-buttons into debounced press events and lets the operator edit two 2-digit BCD limits: pills per bottle and bottles per batch.
- Drives the counter's limit inputs (maxL/maxH, bot_maxL/bot_maxH) and its set-mode controls (EN_set, set).
- Editing is locked out while the line is running.

Parameters:
- DB_CYCLES, 20000: consecutive stable synchronized samples required before a key level is accepted (range 2..65535).
- DEF_PILL_H, 4'd1: reset value, pills-per-bottle tens digit.
- DEF_PILL_L, 4'd0: reset value, pills-per-bottle ones digit.
- DEF_BOT_H, 4'd0: reset value, bottles-per-batch tens digit.
- DEF_BOT_L, 4'd5: reset value, bottles-per-batch ones digit.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- isWork  in  1  line running; high = editing forbidden
- key_mode  in  1  raw button, active-high, bouncy, asynchronous
- key_inc  in  1  raw button
- key_dec  in  1  raw button
- key_ok  in  1  raw button
- maxL  out  4  committed pills-per-bottle, BCD ones
- maxH  out  4  committed pills-per-bottle, BCD tens
- bot_maxL  out  4  committed bottles-per-batch, BCD ones
- bot_maxH  out  4  committed bottles-per-batch, BCD tens
- EN_set  out  1  high while in an edit state
- set  out  1  one-cycle commit strobe
- edit_sel  out  2  00 idle, 01 editing pills, 10 editing bottles
- dispL  out  4  BCD ones of the value under edit (committed pill value when idle)
- dispH  out  4  BCD tens of the same value

Behaviour:
- Reset (asynchronous): maxH/maxL = DEF_PILL_H/L; bot_maxH/L = DEF_BOT_H/L; shadow registers equal the committed values; EN_set=0, set=0, edit_sel=00; dispH/L = DEF_PILL_H/L. Synchronizers, debounce counters and press flags all clear.
- Key path, per key:
  - 2-flop synchronizer, then a stable-count debouncer: the accepted level flips once the synchronized level has differed from it for DB_CYCLES consecutive clocks.
  - A press pulse is the one-cycle rising edge of the accepted level.
  - A raw rise held steady from cycle N produces its press pulse in cycle N+2+DB_CYCLES.
  - A glitch shorter than DB_CYCLES produces no pulse; a release produces no pulse.
- Simultaneous press pulses are resolved by priority ok > mode > inc > dec; the lower-priority pulses in that cycle are dropped.
- FSM states IDLE, EDIT_PILL, EDIT_BOT. Actions take effect on the clock edge after the pulse.
  - IDLE + mode, isWork=0: load both shadows from committed values; go to EDIT_PILL.
  - IDLE + any other key, or any key while isWork=1: ignored.
  - EDIT_PILL + mode: go to EDIT_BOT. EDIT_BOT + mode: go to EDIT_PILL. Shadows are kept.
  - EDIT_* + inc/dec: step the selected shadow as a 2-digit BCD value.
  - EDIT_* + ok: copy both shadows to the outputs, set=1 for exactly one cycle, go to IDLE.
  - EDIT_* with isWork=1 in any cycle: abort to IDLE with no commit, set stays 0, shadows discarded. Abort has priority over all keys in that cycle.
- BCD step rules, legal range 01..99 (00 never produced):
  - inc: ones 9 -> 0 carries into tens; 99 -> 01.
  - dec: ones 0 -> 9 borrows from tens; 01 -> 99.
  - Digits are always 0..9.
- Outputs:
  - EN_set = 1 in EDIT_PILL/EDIT_BOT; edit_sel encodes the state.
  - dispH/L show the selected shadow while editing and the committed pill value in IDLE. All outputs are registered.
- Committed outputs change only on reset or on an ok commit, never mid-batch.
- RST asserted mid-edit returns the block to reset values immediately; pending shadows are lost.

Decomposition:
- Shared package `bottle_pkg`:
  - FSM state encoding (IDLE=2'b00, EDIT_PILL=2'b01, EDIT_BOT=2'b10), reused as edit_sel.
  - Constants BCD_MIN=8'h01 and BCD_MAX=8'h99.
  - Helper functions bcd2_inc and bcd2_dec for 2-digit BCD with wrap.
- One sub-module `key_debounce` (parameter DB_CYCLES; ports CLK, RST, raw, level, press), instantiated four times.

Test Plan (DB_CYCLES=4):
- Reset release -> maxH/L=1/0, bot_maxH/L=0/5, EN_set=0, edit_sel=00, set never pulses.
- key_mode high from cycle N, isWork=0 -> press at N+6; edit_sel=01 and EN_set=1 at N+7; 3-cycle key_inc glitch -> no change.
- In EDIT_PILL from 10: dec×10 -> 99 shown on dispH/L; inc -> 01; ok -> maxH/L=0/1 and set high for exactly one cycle; return to IDLE.
- From EDIT_PILL: mode -> 10; bot inc from 09 -> 10; ok -> bot_maxH/L=1/0 and maxH/L unchanged.
- In EDIT_BOT with a pending edit, isWork=1 -> next cycle edit_sel=00, set=0, outputs unchanged; key_mode while isWork=1 -> ignored.
- ok and inc pulses in the same cycle -> commit only, no increment. RST pulse mid-edit -> immediate return to defaults.

Source files
------------

// File: rtl/bottle_pkg.sv
// Shared definitions for the bottle parameter entry block.
// - state_e : edit FSM state, its encoding doubles as the edit_sel output
// - BCD_MIN / BCD_MAX : legal range of a 2-digit BCD limit
// - bcd2_inc / bcd2_dec : 2-digit BCD step with wrap inside 01..99
package bottle_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StEditPill = 2'b01,
        StEditBot  = 2'b10
    } state_e;

    localparam logic [7:0] BCD_MIN = 8'h01;
    localparam logic [7:0] BCD_MAX = 8'h99;

    // 99 wraps to 01; ones digit 9 carries into tens.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        logic [3:0] h;
        logic [3:0] l;
        h = v[7:4];
        l = v[3:0];
        if (v == BCD_MAX) begin
            return BCD_MIN;
        end else if (l >= 4'd9) begin
            return {h + 4'd1, 4'd0};
        end else begin
            return {h, l + 4'd1};
        end
    endfunction

    // 01 (and a stray 00) wraps to 99; ones digit 0 borrows from tens.
    function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
        logic [3:0] h;
        logic [3:0] l;
        h = v[7:4];
        l = v[3:0];
        if (v <= BCD_MIN) begin
            return BCD_MAX;
        end else if (l == 4'd0) begin
            return {h - 4'd1, 4'd9};
        end else begin
            return {h, l - 4'd1};
        end
    endfunction

endpackage

// File: rtl/bottle_param_entry_key_debounce.sv
// Single push-button conditioner: 2-flop synchronizer followed by a
// stable-count debouncer.
// - CLK, RST : clock, asynchronous active-high reset
// - raw      : bouncy asynchronous button input
// - level    : debounced (accepted) button level
// - press    : one-cycle pulse on the rising edge of level
// A raw rise held from cycle N gives press in cycle N+2+DB_CYCLES.
module key_debounce #(
    parameter int unsigned DB_CYCLES = 20000
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic press
);

    logic        sync1_q, sync2_q;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic [15:0] cnt_q, cnt_d;

    // Counter tracks how long the synchronized level has disagreed with the
    // accepted level; any agreement restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == 16'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/bottle_param_entry.sv
// Operator entry stage for the pill/bottle counter limits.
// - CLK, RST          : clock, asynchronous active-high reset
// - isWork            : line running, locks out and aborts editing
// - key_mode/inc/dec/ok : raw push-buttons
// - maxH/maxL         : committed pills-per-bottle (BCD)
// - bot_maxH/bot_maxL : committed bottles-per-batch (BCD)
// - EN_set, set       : edit-mode flag and one-cycle commit strobe
// - edit_sel          : 00 idle, 01 editing pills, 10 editing bottles
// - dispH/dispL       : value under edit, committed pill value when idle
module bottle_param_entry
    import bottle_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 20000,
    parameter logic [3:0]  DEF_PILL_H = 4'd1,
    parameter logic [3:0]  DEF_PILL_L = 4'd0,
    parameter logic [3:0]  DEF_BOT_H  = 4'd0,
    parameter logic [3:0]  DEF_BOT_L  = 4'd5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       isWork,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic       key_ok,
    output logic [3:0] maxL,
    output logic [3:0] maxH,
    output logic [3:0] bot_maxL,
    output logic [3:0] bot_maxH,
    output logic       EN_set,
    output logic       set,
    output logic [1:0] edit_sel,
    output logic [3:0] dispL,
    output logic [3:0] dispH
);

    localparam logic [7:0] DefPill = {DEF_PILL_H, DEF_PILL_L};
    localparam logic [7:0] DefBot  = {DEF_BOT_H, DEF_BOT_L};

    // Index order: 0 mode, 1 inc, 2 dec, 3 ok
    logic [3:0] key_raw, key_level, key_press;

    assign key_raw = {key_ok, key_dec, key_inc, key_mode};

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_key_debounce (
            .CLK  (CLK),
            .RST  (RST),
            .raw  (key_raw[k]),
            .level(key_level[k]),
            .press(key_press[k])
        );
    end

    // A press always coincides with a high accepted level; gating keeps the
    // pulse honest should the two ever disagree.
    logic p_ok, p_mode, p_inc, p_dec;
    logic [3:0] p_raw;
    assign p_raw  = key_press & key_level;
    assign p_ok   = p_raw[3];
    assign p_mode = p_raw[0] & ~p_raw[3];
    assign p_inc  = p_raw[1] & ~p_raw[3] & ~p_raw[0];
    assign p_dec  = p_raw[2] & ~p_raw[3] & ~p_raw[0] & ~p_raw[1];

    state_e     state_q, state_d;
    logic [7:0] pill_q, pill_d;
    logic [7:0] bot_q, bot_d;
    logic [7:0] pill_sh_q, pill_sh_d;
    logic [7:0] bot_sh_q, bot_sh_d;
    logic [7:0] disp_q, disp_d;
    logic       set_q, set_d;

    always_comb begin
        state_d   = state_q;
        pill_d    = pill_q;
        bot_d     = bot_q;
        pill_sh_d = pill_sh_q;
        bot_sh_d  = bot_sh_q;
        set_d     = 1'b0;

        if (isWork) begin
            // Running line: abort any edit, ignore all keys.
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (p_mode) begin
                        pill_sh_d = pill_q;
                        bot_sh_d  = bot_q;
                        state_d   = StEditPill;
                    end
                end
                StEditPill, StEditBot: begin
                    if (p_ok) begin
                        pill_d  = pill_sh_q;
                        bot_d   = bot_sh_q;
                        set_d   = 1'b1;
                        state_d = StIdle;
                    end else if (p_mode) begin
                        state_d = (state_q == StEditPill) ? StEditBot : StEditPill;
                    end else if (p_inc) begin
                        if (state_q == StEditPill) pill_sh_d = bcd2_inc(pill_sh_q);
                        else                       bot_sh_d  = bcd2_inc(bot_sh_q);
                    end else if (p_dec) begin
                        if (state_q == StEditPill) pill_sh_d = bcd2_dec(pill_sh_q);
                        else                       bot_sh_d  = bcd2_dec(bot_sh_q);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Display follows the next state so it stays aligned with edit_sel.
        case (state_d)
            StEditPill: disp_d = pill_sh_d;
            StEditBot:  disp_d = bot_sh_d;
            default:    disp_d = pill_d;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            pill_q    <= DefPill;
            bot_q     <= DefBot;
            pill_sh_q <= DefPill;
            bot_sh_q  <= DefBot;
            disp_q    <= DefPill;
            set_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pill_q    <= pill_d;
            bot_q     <= bot_d;
            pill_sh_q <= pill_sh_d;
            bot_sh_q  <= bot_sh_d;
            disp_q    <= disp_d;
            set_q     <= set_d;
        end
    end

    assign maxH     = pill_q[7:4];
    assign maxL     = pill_q[3:0];
    assign bot_maxH = bot_q[7:4];
    assign bot_maxL = bot_q[3:0];
    assign EN_set   = (state_q != StIdle);
    assign edit_sel = state_q;
    assign set      = set_q;
    assign dispH    = disp_q[7:4];
    assign dispL    = disp_q[3:0];

endmodule

// File: tb/tb_bottle_param_entry.sv
module tb_bottle_param_entry;

    localparam int DB = 4;
    localparam int HOLD = DB + 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       isWork = 1'b0;
    logic       key_mode = 1'b0, key_inc = 1'b0, key_dec = 1'b0, key_ok = 1'b0;
    logic [3:0] maxL, maxH, bot_maxL, bot_maxH, dispL, dispH;
    logic       EN_set, set;
    logic [1:0] edit_sel;

    bottle_param_entry #(
        .DB_CYCLES(DB)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .isWork  (isWork),
        .key_mode(key_mode),
        .key_inc (key_inc),
        .key_dec (key_dec),
        .key_ok  (key_ok),
        .maxL    (maxL),
        .maxH    (maxH),
        .bot_maxL(bot_maxL),
        .bot_maxH(bot_maxH),
        .EN_set  (EN_set),
        .set     (set),
        .edit_sel(edit_sel),
        .dispL   (dispL),
        .dispH   (dispH)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int set_cnt = 0;
    int set_long = 0;
    logic set_prev = 1'b0;

    // Count set pulses and flag any pulse wider than one cycle.
    always @(negedge CLK) begin
        if (set === 1'b1) set_cnt++;
        if (set === 1'b1 && set_prev === 1'b1) set_long++;
        set_prev = set;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Keys: 0 mode, 1 inc, 2 dec, 3 ok
    task automatic set_key(input int k, input logic v);
        case (k)
            0: key_mode = v;
            1: key_inc  = v;
            2: key_dec  = v;
            default: key_ok = v;
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press_key(input int k, input logic w);
        isWork = w;
        set_key(k, 1'b1);
        tick(HOLD);
        set_key(k, 1'b0);
        tick(HOLD);
    endtask

    task automatic chk_all(input string tag, input int sel, input int disp, input int pill,
                           input int bot, input int set_delta, input int set_before);
        chk({tag, ".sel"}, 32'(edit_sel), 32'(sel));
        chk({tag, ".en"}, 32'(EN_set), 32'(sel != 0));
        chk({tag, ".disp"}, 32'(dispH) * 10 + 32'(dispL), 32'(disp));
        chk({tag, ".pill"}, 32'(maxH) * 10 + 32'(maxL), 32'(pill));
        chk({tag, ".bot"}, 32'(bot_maxH) * 10 + 32'(bot_maxL), 32'(bot));
        chk({tag, ".set"}, 32'(set_cnt - set_before), 32'(set_delta));
    endtask

    // Behavioural model on plain integers.
    int m_state, m_pill, m_bot, m_sp, m_sb;

    function automatic int inc99(input int v);
        return (v >= 99) ? 1 : v + 1;
    endfunction

    function automatic int dec99(input int v);
        return (v <= 1) ? 99 : v - 1;
    endfunction

    task automatic model_press(input int k, input logic w, output int commit);
        commit = 0;
        if (w) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (k == 0) begin
                m_sp = m_pill;
                m_sb = m_bot;
                m_state = 1;
            end
        end else begin
            case (k)
                0: m_state = 3 - m_state;
                1: if (m_state == 1) m_sp = inc99(m_sp); else m_sb = inc99(m_sb);
                2: if (m_state == 1) m_sp = dec99(m_sp); else m_sb = dec99(m_sb);
                default: begin
                    m_pill = m_sp;
                    m_bot = m_sb;
                    m_state = 0;
                    commit = 1;
                end
            endcase
        end
    endtask

    function automatic int model_disp();
        return (m_state == 0) ? m_pill : ((m_state == 1) ? m_sp : m_sb);
    endfunction

    typedef struct {
        int   key;
        logic work;
        int   sel;
        int   disp;
        int   pill;
        int   bot;
        int   setd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int k, logic w, int s, int d, int p, int b, int sd);
        vec_t v;
        v.key = k; v.work = w; v.sel = s; v.disp = d; v.pill = p; v.bot = b; v.setd = sd;
        return v;
    endfunction

    initial begin
        int sb, commit, k;
        logic w;

        // Edit pills 10 -> dec x10 -> 99 -> inc -> 01 -> commit.
        vecs.push_back(mk(0, 0, 1, 10, 10, 5, 0));
        for (int i = 1; i <= 9; i++) vecs.push_back(mk(2, 0, 1, 10 - i, 10, 5, 0));
        vecs.push_back(mk(2, 0, 1, 99, 10, 5, 0));
        vecs.push_back(mk(1, 0, 1, 1, 10, 5, 0));
        vecs.push_back(mk(3, 0, 0, 1, 1, 5, 1));
        // Edit bottles 05 -> 10 -> commit; pills unchanged.
        vecs.push_back(mk(0, 0, 1, 1, 1, 5, 0));
        vecs.push_back(mk(0, 0, 2, 5, 1, 5, 0));
        for (int i = 6; i <= 10; i++) vecs.push_back(mk(1, 0, 2, i, 1, 5, 0));
        vecs.push_back(mk(3, 0, 0, 1, 1, 10, 1));
        // Pending bottle edit aborted by isWork; keys ignored while running.
        vecs.push_back(mk(0, 0, 1, 1, 1, 10, 0));
        vecs.push_back(mk(0, 0, 2, 10, 1, 10, 0));
        vecs.push_back(mk(2, 0, 2, 9, 1, 10, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 10, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 10, 0));

        // Reset values.
        tick(3);
        RST = 1'b0;
        tick(1);
        chk_all("reset", 0, 10, 10, 5, 0, 0);

        foreach (vecs[i]) begin
            sb = set_cnt;
            press_key(vecs[i].key, vecs[i].work);
            chk_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].disp, vecs[i].pill,
                    vecs[i].bot, vecs[i].setd, sb);
        end
        isWork = 1'b0;
        tick(2);

        // Exact latency: raw rise in cycle N, press in N+6, state change in N+7.
        key_mode = 1'b1;
        tick(6);
        chk("lat.n6_sel", 32'(edit_sel), 32'd0);
        tick(1);
        chk("lat.n7_sel", 32'(edit_sel), 32'd1);
        chk("lat.n7_en", 32'(EN_set), 32'd1);
        key_mode = 1'b0;
        tick(HOLD);

        // 3-cycle glitch on inc must not step the value.
        key_inc = 1'b1;
        tick(3);
        key_inc = 1'b0;
        tick(HOLD + 2);
        chk("glitch.disp", 32'(dispH) * 10 + 32'(dispL), 32'd1);

        // Abort from EDIT_BOT without any key press.
        press_key(1, 1'b0);
        press_key(0, 1'b0);
        press_key(1, 1'b0);
        chk("abort.pre_disp", 32'(dispH) * 10 + 32'(dispL), 32'd11);
        sb = set_cnt;
        isWork = 1'b1;
        tick(1);
        chk_all("abort", 0, 1, 1, 10, 0, sb);
        isWork = 1'b0;
        tick(2);

        // ok and inc in the same cycle: commit only.
        press_key(0, 1'b0);
        press_key(1, 1'b0);
        sb = set_cnt;
        key_ok = 1'b1;
        key_inc = 1'b1;
        tick(HOLD);
        key_ok = 1'b0;
        key_inc = 1'b0;
        tick(HOLD);
        chk_all("okinc", 0, 2, 2, 10, 1, sb);

        // Randomized presses against the model.
        m_state = 0; m_pill = 2; m_bot = 10; m_sp = 2; m_sb = 10;
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 3));
            if (i < 4) k = 0;
            w = ($urandom_range(0, 7) == 0);
            sb = set_cnt;
            press_key(k, w);
            model_press(k, w, commit);
            chk_all($sformatf("rnd%0d", i), m_state, model_disp(), m_pill, m_bot, commit, sb);
        end
        isWork = 1'b0;
        tick(2);

        // RST mid-edit returns to defaults immediately.
        if (!EN_set) press_key(0, 1'b0);
        press_key(1, 1'b0);
        sb = set_cnt;
        #2;
        RST = 1'b1;
        #1;
        chk_all("rst", 0, 10, 10, 5, 0, sb);
        tick(2);
        RST = 1'b0;
        tick(1);
        press_key(0, 1'b0);
        chk_all("post_rst", 1, 10, 10, 5, 0, sb);

        chk("set_width", 32'(set_long), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
